// File: rtl/mips_inst_mem.sv
// Word-organised instruction memory for the single-cycle MIPS fetch path.
// Combinational byte-addressed read, synchronous word load, reset restores the boot program.
module mips_inst_mem #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    output logic [31:0] inst,
    output logic        misaligned,
    output logic        out_of_range,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [31:0] mem_t [DEPTH];

    localparam mem_t BOOT_IMAGE = '{
        0:       32'h2008_0005,
        1:       32'h2009_0003,
        2:       32'h0109_5020,
        3:       32'h0800_0003,
        default: 32'h0000_0000
    };

    // Declaration initialiser gives the boot image from time zero without a reset.
    mem_t mem = BOOT_IMAGE;

    logic          rd_in_range;
    logic          wr_in_range;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    assign rd_in_range = (addr[31:2] < 30'(DEPTH));
    assign wr_in_range = (load_addr[31:2] < 30'(DEPTH));
    assign rd_idx      = addr[AW+1:2];
    assign wr_idx      = load_addr[AW+1:2];

    assign inst         = rd_in_range ? mem[rd_idx] : 32'h0000_0000;
    assign misaligned   = |addr[1:0];
    assign out_of_range = ~rd_in_range;

    // Reset wins over a same-edge load; out-of-range loads are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= BOOT_IMAGE;
        end else if (load_en && wr_in_range) begin
            mem[wr_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_mips_inst_mem.sv
// Directed scoreboard bench for mips_inst_mem: expectations are queued as stimulus
// is driven and popped when the combinational outputs are sampled.
module tb_mips_inst_mem;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        misaligned;
    logic        out_of_range;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    typedef struct packed {
        logic [31:0] inst;
        logic        mis;
        logic        oor;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    mips_inst_mem #(.DEPTH(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .inst         (inst),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] i, input logic m, input logic o);
        exp_t e;
        e.inst = i;
        e.mis  = m;
        e.oor  = o;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty, got inst=%h", tag, inst);
            return;
        end
        e = sb.pop_front();
        assert (inst === e.inst) else begin
            bad++;
            $error("FAIL %s inst got=%h want=%h", tag, inst, e.inst);
        end
        total++;
        assert (misaligned === e.mis) else begin
            bad++;
            $error("FAIL %s misaligned got=%b want=%b", tag, misaligned, e.mis);
        end
        total++;
        assert (out_of_range === e.oor) else begin
            bad++;
            $error("FAIL %s out_of_range got=%b want=%b", tag, out_of_range, e.oor);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] i, input logic m, input logic o);
        addr = a;
        push(i, m, o);
        #1;
        chk(tag);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] boot [4];

    initial begin
        boot[0] = 32'h2008_0005;
        boot[1] = 32'h2009_0003;
        boot[2] = 32'h0109_5020;
        boot[3] = 32'h0800_0003;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        load_en = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
        addr = 32'h0;

        // Power-up contents before any clock edge
        rd("powerup_w0", 32'h0, boot[0], 1'b0, 1'b0);

        // Boot image after a one-cycle reset pulse
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            rd("boot_sweep", 32'(i * 4), boot[i], 1'b0, 1'b0);
        rd("boot_sweep_w4", 32'h10, 32'h0, 1'b0, 1'b0);

        // Load and read-back of the same word around the capturing edge
        load_en   = 1'b1;
        load_addr = 32'h40;
        load_data = 32'hDEAD_BEEF;
        rd("load_before_edge", 32'h40, 32'h0, 1'b0, 1'b0);
        edge_step();
        load_en = 1'b0;
        rd("load_after_edge", 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0);
        rd("load_misaligned", 32'h41, 32'hDEAD_BEEF, 1'b1, 1'b0);
        rd("misaligned_3", 32'h43, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Range limits
        load_en   = 1'b1;
        load_addr = 32'h3FE;
        load_data = 32'hCAFE_F00D;
        edge_step();
        load_en = 1'b0;
        rd("last_word", 32'h3FC, 32'hCAFE_F00D, 1'b0, 1'b0);
        rd("past_end", 32'h400, 32'h0, 1'b0, 1'b1);
        rd("past_end_mis", 32'h402, 32'h0, 1'b1, 1'b1);
        rd("far_out", 32'h8000_0000, 32'h0, 1'b0, 1'b1);
        load_en   = 1'b1;
        load_addr = 32'h400;
        load_data = 32'h5555_5555;
        edge_step();
        load_addr = 32'h8000_0004;
        edge_step();
        load_en = 1'b0;
        rd("oor_load_w0", 32'h000, boot[0], 1'b0, 1'b0);
        rd("oor_load_w1", 32'h004, boot[1], 1'b0, 1'b0);
        rd("oor_load_last", 32'h3FC, 32'hCAFE_F00D, 1'b0, 1'b0);
        rd("oor_load_w16", 32'h040, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Reset has priority over a same-edge load
        reset     = 1'b1;
        load_en   = 1'b1;
        load_addr = 32'h0;
        load_data = 32'h1234_5678;
        edge_step();
        reset   = 1'b0;
        load_en = 1'b0;
        rd("rst_prio_w0", 32'h0, boot[0], 1'b0, 1'b0);
        rd("rst_clears_w16", 32'h40, 32'h0, 1'b0, 1'b0);
        rd("rst_clears_last", 32'h3FC, 32'h0, 1'b0, 1'b0);

        // Back-to-back program load then reset
        load_en   = 1'b1;
        load_data = 32'hAAAA_AAAA;
        for (int i = 0; i < 8; i++) begin
            load_addr = 32'(i * 4);
            edge_step();
        end
        load_en = 1'b0;
        for (int i = 0; i < 8; i++)
            rd("prog_loaded", 32'(i * 4), 32'hAAAA_AAAA, 1'b0, 1'b0);
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            rd("prog_reset", 32'(i * 4), (i < 4) ? boot[i] : 32'h0, 1'b0, 1'b0);

        // Fetch integration: PC advances every cycle with no bubble
        for (int pc = 0; pc < 8; pc++)
            push((pc < 4) ? boot[pc] : 32'h0, 1'b0, 1'b0);
        for (int pc = 0; pc < 8; pc++) begin
            addr = {pc[29:0], 2'b00};
            #1;
            chk("fetch_seq");
            edge_step();
        end

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
